lbp_param: RTL

LBP_PARAM -- requirements
Module: lbp_param

---
 rtl/lbp_param.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/lbp_param.sv
// rtl/lbp_param.sv - 3x3 local binary pattern engine over a gray frame in memory; define LBP_UNIFORM_EN for riu2 codes
module lbp_param #(
   parameter int IMG_W = 128,
   parameter int IMG_H = 128,
   parameter int AW    = 14,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          cmp_gt,
   output logic          gray_req,
   input  logic          gray_ready,
   output logic [AW-1:0] gray_addr,
   input  logic [DW-1:0] gray_data,
   output logic          lbp_valid,
   output logic [AW-1:0] lbp_addr,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FILL  = 3'd1,
      S_SHIFT = 3'd2,
      S_CALC  = 3'd3,
      S_WRITE = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [10:0]   row_q, col_q;
   logic [10:0]   rd_row, rd_col;
   logic [1:0]    rd_r_q, rd_c_q;
   logic          issued_q, pend_q, cmp_gt_q;
   logic [3:0]    pend_slot_q, rd_slot;
   // Window slots are column-major: slot = col*3 + row (0..2 left, 3..5 centre, 6..8 right)
   logic [DW-1:0] win_q [9];
   logic [AW-1:0] lbp_addr_q, pix_addr;
   logic [7:0]    lbp_data_q, pattern, code;
   logic          accept, last_col, last_row, frame_go;

   function automatic logic nb_cmp(input logic [DW-1:0] n, input logic [DW-1:0] c, input logic gt);
      return gt ? (n > c) : (n >= c);
   endfunction

   assign frame_go  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign last_col  = (col_q == 11'(IMG_W - 2));
   assign last_row  = (row_q == 11'(IMG_H - 2));
   assign gray_req  = ((state_q == S_FILL) || (state_q == S_SHIFT)) && !issued_q;
   assign accept    = gray_req && gray_ready;
   assign rd_row    = row_q - 11'd1 + {9'd0, rd_r_q};
   assign rd_col    = col_q - 11'd1 + {9'd0, rd_c_q};
   assign rd_slot   = 4'(rd_c_q) * 4'd3 + 4'(rd_r_q);
   assign gray_addr = gray_req ? (AW'(rd_row) * AW'(IMG_W) + AW'(rd_col)) : '0;
   assign pix_addr  = AW'(row_q) * AW'(IMG_W) + AW'(col_q);
   assign lbp_valid = (state_q == S_WRITE);
   assign lbp_addr  = lbp_addr_q;
   assign lbp_data  = lbp_data_q;
   assign finish    = (state_q == S_DONE);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next-state: reads finish when the last accepted datum lands, then CALC and WRITE
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:           if (start) state_d = S_FILL;
         S_FILL, S_SHIFT:  if (issued_q && pend_q) state_d = S_CALC;
         S_CALC:           state_d = S_WRITE;
         S_WRITE: begin
            if (last_col && last_row) state_d = S_DONE;
            else if (last_col)        state_d = S_FILL;
            else                      state_d = S_SHIFT;
         end
         S_DONE:           if (start) state_d = S_FILL;
         default:          state_d = S_IDLE;
      endcase
   end

   // Read sequencing, window capture/shift, pixel position and result registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         row_q       <= '0;
         col_q       <= '0;
         rd_r_q      <= '0;
         rd_c_q      <= '0;
         issued_q    <= 1'b0;
         pend_q      <= 1'b0;
         pend_slot_q <= '0;
         cmp_gt_q    <= 1'b0;
         lbp_addr_q  <= '0;
         lbp_data_q  <= '0;
         for (int i = 0; i < 9; i++) win_q[i] <= '0;
      end else begin
         pend_q <= accept;
         if (accept) begin
            pend_slot_q <= rd_slot;
            if (rd_r_q == 2'd2) begin
               rd_r_q <= 2'd0;
               rd_c_q <= rd_c_q + 2'd1;
               if (rd_c_q == 2'd2) issued_q <= 1'b1;
            end else begin
               rd_r_q <= rd_r_q + 2'd1;
            end
         end
         if (pend_q) win_q[pend_slot_q] <= gray_data;
         if (frame_go) begin
            row_q    <= 11'd1;
            col_q    <= 11'd1;
            cmp_gt_q <= cmp_gt;
            rd_r_q   <= 2'd0;
            rd_c_q   <= 2'd0;
            issued_q <= 1'b0;
         end
         if (state_q == S_CALC) begin
            lbp_data_q <= code;
            lbp_addr_q <= pix_addr;
         end
         if (state_q == S_WRITE) begin
            rd_r_q   <= 2'd0;
            issued_q <= 1'b0;
            if (last_col) begin
               row_q  <= row_q + 11'd1;
               col_q  <= 11'd1;
               rd_c_q <= 2'd0;
            end else begin
               // Keep the two right columns, only the new right column is fetched
               col_q  <= col_q + 11'd1;
               rd_c_q <= 2'd2;
               for (int i = 0; i < 6; i++) win_q[i] <= win_q[i+3];
            end
         end
      end
   end

   // Neighbour comparison against the centre (slot 4)
   always_comb begin
      pattern    = '0;
      pattern[0] = nb_cmp(win_q[0], win_q[4], cmp_gt_q);
      pattern[1] = nb_cmp(win_q[3], win_q[4], cmp_gt_q);
      pattern[2] = nb_cmp(win_q[6], win_q[4], cmp_gt_q);
      pattern[3] = nb_cmp(win_q[1], win_q[4], cmp_gt_q);
      pattern[4] = nb_cmp(win_q[7], win_q[4], cmp_gt_q);
      pattern[5] = nb_cmp(win_q[2], win_q[4], cmp_gt_q);
      pattern[6] = nb_cmp(win_q[5], win_q[4], cmp_gt_q);
      pattern[7] = nb_cmp(win_q[8], win_q[4], cmp_gt_q);
   end

`ifdef LBP_UNIFORM_EN
   logic [7:0] ring;
   logic [3:0] trans, ones;

   // riu2: walk the ring in circular neighbour order, count 0/1 transitions
   always_comb begin
      ring  = {pattern[3], pattern[5], pattern[6], pattern[7],
               pattern[4], pattern[2], pattern[1], pattern[0]};
      trans = '0;
      ones  = '0;
      for (int i = 0; i < 8; i++) begin
         trans = trans + 4'(ring[i] ^ ring[(i + 1) % 8]);
         ones  = ones + 4'(pattern[i]);
      end
      code = (trans <= 4'd2) ? {4'd0, ones} : 8'd9;
   end
`else
   assign code = pattern;
`endif

endmodule
